board_row_fetcher: RTL and testbench
====================================

Name: board_row_fetcher

Overview:
Upstream feeder for the VGA color mapper. On each row-load request it reads the 10 cells of the requested board row from the synchronous board RAM and overlays the active falling piece. It then presents the finished row to the mapper as Row[10], with a one-cycle rowReady pulse. Cells are double-buffered, so Row never changes mid-fetch.

Parameters:
BOARD_W, 10, cells per board row
BOARD_H, 20, rows on board; requests with rowNum >= BOARD_H return a blank row
ADDR_W, 8, board RAM address width (row-major, addr = row*BOARD_W + col, max 199)
DATA_W, 16, cell width; [11:0] = 4:4:4 RGB, [15:12] = piece id, passed through untouched

Ports:
Clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
LD_Row  in  1  row-load request from color mapper (level; may stay high many cycles)
rowNum  in  8  requested board row, sampled on the accepting edge
mem_addr  out  ADDR_W  board RAM read address
mem_rd  out  1  board RAM read enable
mem_data  in  DATA_W  board RAM read data, valid one cycle after address
piece_valid  in  1  active piece overlay enable
piece_x  in  4 x 4  column of each of the 4 active-piece blocks
piece_y  in  4 x 5  row of each of the 4 active-piece blocks
piece_color  in  DATA_W  cell value written for active-piece blocks
Row  out  BOARD_W x DATA_W  committed row, held stable between commits
rowReady  out  1  one-cycle pulse coincident with the Row update
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: request edge seen while busy

Behaviour:
- Reset (async, active-high): state=IDLE, Row all 0, shadow all 0, rowReady=0, mem_rd=0, mem_addr=0, col=0, overrun=0, LD_Row_q=0. Reset mid-fetch aborts the fetch; Row keeps no partial data.
- Request accept: a request is the rising edge of LD_Row (LD_Row & ~LD_Row_q, where LD_Row_q is registered every cycle).
  - Accepted only in IDLE. A held LD_Row yields exactly one fetch.
  - A rising edge while busy is dropped and sets overrun.
- States: IDLE, FETCH, DRAIN, COMMIT.
- IDLE -> FETCH on accept with rowNum < BOARD_H.
  - Latch row_q = rowNum.
  - Latch base = rowNum*10, computed as (rowNum<<3)+(rowNum<<1) in ADDR_W bits.
  - Set col=0.
- IDLE -> COMMIT on accept with rowNum >= BOARD_H; shadow cleared to all 0 on the same edge.
- FETCH:
  - Drive mem_rd=1, mem_addr=base+col.
  - col increments each cycle.
  - From the second FETCH cycle, capture shadow[col-1] from mem_data.
  - After the cycle with col=BOARD_W-1, go to DRAIN.
- DRAIN: mem_rd=0; capture shadow[BOARD_W-1]; go to COMMIT.
- COMMIT: Row <= shadow on the exiting edge; rowReady high for exactly the following cycle; return to IDLE.
- Overlay at each capture of column k: if piece_valid and any i in 0..3 has piece_x[i]==k and piece_y[i]==row_q, store piece_color; otherwise store mem_data. Multiple matching blocks give the same result.
- Latency, valid row: Row updates and rowReady rises 12 edges after the accepting edge (10 FETCH + DRAIN + COMMIT). This is well inside one horizontal blank.
- Latency, out-of-range row: 1 edge after the accepting edge; no RAM reads issued.
- mem_addr is 0 whenever mem_rd=0.
- Piece inputs are sampled at each capture edge; upstream holds them stable per frame.

Test Plan:
- Basic fetch: RAM preloaded with cell(a) = 16'h0100+a; reset, pulse LD_Row with rowNum=3 -> mem_addr 30..39 on consecutive cycles; 12 edges later Row[k]=16'h011E+k; rowReady high 1 cycle; busy low afterward.
- Overlay: piece_valid=1, blocks (4,5),(5,5),(5,6),(6,5), piece_color=16'hF0F0, rowNum=5 -> Row[4],Row[5],Row[6]=16'hF0F0; other columns from RAM. Repeat with piece_valid=0 -> all columns from RAM.
- Out-of-range: rowNum=20 -> no mem_rd; Row all 0 and rowReady one edge after accept. rowNum=19, col 9 -> mem_addr reaches 199.
- Held request: LD_Row high for 40 cycles with rowNum=7 -> exactly one fetch, one rowReady pulse, overrun stays 0.
- Overrun: second LD_Row rising edge 4 cycles into a fetch -> overrun=1 (sticky); the in-flight row completes normally; the second request is not serviced.
- Reset mid-fetch: assert reset at the 5th FETCH cycle -> all outputs zero immediately; after release, a new request for row 0 completes with correct data and no stale columns.

Source files
------------

// File: rtl/board_row_fetcher_if.sv
// Bundle of request, board-RAM, piece-overlay and row-output signals between
// the color mapper side and the row fetcher.
interface board_row_fetcher_if #(
    parameter int BOARD_W = 10,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
);
    logic                            LD_Row;
    logic [7:0]                      rowNum;
    logic [ADDR_W-1:0]               mem_addr;
    logic                            mem_rd;
    logic [DATA_W-1:0]               mem_data;
    logic                            piece_valid;
    logic [3:0][3:0]                 piece_x;
    logic [3:0][4:0]                 piece_y;
    logic [DATA_W-1:0]               piece_color;
    logic [BOARD_W-1:0][DATA_W-1:0]  Row;
    logic                            rowReady;
    logic                            busy;
    logic                            overrun;

    modport master (
        output LD_Row, rowNum, mem_data, piece_valid, piece_x, piece_y, piece_color,
        input  mem_addr, mem_rd, Row, rowReady, busy, overrun
    );

    modport slave (
        input  LD_Row, rowNum, mem_data, piece_valid, piece_x, piece_y, piece_color,
        output mem_addr, mem_rd, Row, rowReady, busy, overrun
    );
endinterface

// File: rtl/board_row_fetcher.sv
// Fetches one board row from synchronous RAM, overlays the falling piece into a
// shadow buffer, then commits the finished row to the mapper in a single edge.
module board_row_fetcher #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
) (
    input  logic              Clk,
    input  logic              reset,
    board_row_fetcher_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam logic [7:0] ROW_LIMIT = 8'(BOARD_H);
    localparam logic [3:0] LAST_COL  = 4'(BOARD_W - 1);

    // True when any of the four active-piece blocks sits on cell (k, r).
    function automatic logic piece_hit(input logic [3:0] k, input logic [7:0] r,
                                       input logic v, input logic [3:0][3:0] px,
                                       input logic [3:0][4:0] py);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hit = hit | (v & (px[i] == k) & ({3'b000, py[i]} == r));
        end
        return hit;
    endfunction

    state_e                          state_q, state_d;
    logic [3:0]                      col_q, col_d;
    logic [ADDR_W-1:0]               base_q, base_d;
    logic [7:0]                      row_q, row_d;
    logic                            ld_q;
    logic [BOARD_W-1:0][DATA_W-1:0]  shadow_q, shadow_d;
    logic [BOARD_W-1:0][DATA_W-1:0]  row_out_q, row_out_d;
    logic                            ready_q, ready_d;
    logic                            busy_q, busy_d;
    logic                            overrun_q, overrun_d;
    logic                            mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]               mem_addr_q, mem_addr_d;
    logic                            req_s;
    logic [ADDR_W-1:0]               rn_s;
    logic [3:0]                      cap_col_s;
    logic [DATA_W-1:0]               cell_s;

    assign req_s     = bus.LD_Row & ~ld_q;
    assign rn_s      = ADDR_W'(bus.rowNum);
    // RAM data lags the address by one cycle, so FETCH captures the previous column.
    assign cap_col_s = (state_q == DRAIN) ? LAST_COL : (col_q - 4'd1);
    assign cell_s    = piece_hit(cap_col_s, row_q, bus.piece_valid, bus.piece_x, bus.piece_y)
                       ? bus.piece_color : bus.mem_data;

    // State and control registers.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= 4'd0;
            base_q  <= '0;
            row_q   <= 8'd0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            base_q  <= base_d;
            row_q   <= row_d;
            ld_q    <= bus.LD_Row;
        end
    end

    // Next-state logic: request accept, column walk, drain and commit.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        base_d  = base_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (req_s && (bus.rowNum < ROW_LIMIT)) begin
                    state_d = FETCH;
                    row_d   = bus.rowNum;
                    base_d  = (rn_s << 3) + (rn_s << 1);
                    col_d   = 4'd0;
                end else if (req_s) begin
                    state_d = COMMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (col_q == LAST_COL) begin
                    state_d = DRAIN;
                    col_d   = 4'd0;
                end else begin
                    col_d   = col_q + 4'd1;
                end
            end
            DRAIN:   state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; RAM controls are registered from next state.
    always_comb begin
        shadow_d   = shadow_q;
        row_out_d  = row_out_q;
        ready_d    = 1'b0;
        overrun_d  = overrun_q | (req_s & (state_q != IDLE));
        busy_d     = (state_d != IDLE);
        mem_rd_d   = (state_d == FETCH);
        mem_addr_d = mem_rd_d ? (base_d + ADDR_W'(col_d)) : '0;
        case (state_q)
            IDLE: begin
                if (req_s && (bus.rowNum >= ROW_LIMIT)) begin
                    shadow_d = '0;
                end else begin
                    shadow_d = shadow_q;
                end
            end
            FETCH: begin
                if (col_q != 4'd0) begin
                    shadow_d[cap_col_s] = cell_s;
                end else begin
                    shadow_d = shadow_q;
                end
            end
            DRAIN:   shadow_d[cap_col_s] = cell_s;
            COMMIT: begin
                row_out_d = shadow_q;
                ready_d   = 1'b1;
            end
            default: shadow_d = shadow_q;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            shadow_q   <= '0;
            row_out_q  <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            row_out_q  <= row_out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.Row      = row_out_q;
    assign bus.rowReady = ready_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_board_row_fetcher.sv
// Bench for board_row_fetcher: RAM model, transaction-level reference model,
// per-cycle compare, directed scenarios and a randomized request loop.
module tb_board_row_fetcher;
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int RW      = BOARD_W * DATA_W;

    logic Clk   = 1'b0;
    logic reset = 1'b0;
    always #5 Clk = ~Clk;

    board_row_fetcher_if #(.BOARD_W(BOARD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    board_row_fetcher #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W))
        dut (.Clk(Clk), .reset(reset), .bus(bus));

    int tests  = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Board RAM: synchronous read, data one cycle after address.
    logic [DATA_W-1:0] ram [0:255];
    logic [DATA_W-1:0] ram_dout = '0;
    always @(posedge Clk) begin
        if (bus.mem_rd) ram_dout <= ram[bus.mem_addr];
    end
    assign bus.mem_data = ram_dout;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected contents of board row r with the current piece overlay.
    function automatic logic [RW-1:0] expect_row(input int r);
        logic [RW-1:0] v;
        logic hit;
        v = '0;
        for (int k = 0; k < BOARD_W; k++) begin
            hit = 1'b0;
            for (int i = 0; i < 4; i++)
                if (bus.piece_valid && int'(bus.piece_x[i]) == k && int'(bus.piece_y[i]) == r) hit = 1'b1;
            v[k*DATA_W +: DATA_W] = hit ? bus.piece_color : ram[r*BOARD_W + k];
        end
        return v;
    endfunction

    // Reference model: a request occupies a fixed number of edges, then publishes its row.
    logic          m_ld_prev = 1'b0;
    int            m_rem     = 0;
    logic          m_fetch   = 1'b0;
    int            m_base    = 0;
    logic [RW-1:0] m_pend    = '0;
    logic [RW-1:0] m_row     = '0;
    logic          m_ready   = 1'b0;
    logic          m_overrun = 1'b0;
    wire           m_edge    = bus.LD_Row && !m_ld_prev;

    always @(posedge Clk or posedge reset) begin
        if (reset) begin
            m_ld_prev <= 1'b0; m_rem <= 0; m_fetch <= 1'b0; m_pend <= '0;
            m_row <= '0; m_ready <= 1'b0; m_overrun <= 1'b0;
        end else begin
            m_ld_prev <= bus.LD_Row;
            m_ready   <= 1'b0;
            if (m_rem > 0) begin
                if (m_edge) m_overrun <= 1'b1;
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_row <= m_pend; m_ready <= 1'b1; m_fetch <= 1'b0;
                end
            end else if (m_edge) begin
                if (int'(bus.rowNum) < BOARD_H) begin
                    m_pend  <= expect_row(int'(bus.rowNum));
                    m_rem   <= 12;
                    m_fetch <= 1'b1;
                    m_base  <= int'(bus.rowNum) * BOARD_W;
                end else begin
                    m_pend <= '0; m_rem <= 1; m_fetch <= 1'b0;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus event counters used by directed checks.
    int ready_cnt = 0;
    int addr199_cnt = 0;
    always @(negedge Clk) begin
        logic exp_rd;
        int   exp_addr;
        if (chk_en) begin
            exp_rd   = m_fetch && (m_rem >= 3);
            exp_addr = exp_rd ? (m_base + 12 - m_rem) : 0;
            check("Row",      RW'(bus.Row), m_row);
            check("rowReady", RW'(bus.rowReady), RW'(m_ready));
            check("busy",     RW'(bus.busy), RW'(m_rem > 0));
            check("overrun",  RW'(bus.overrun), RW'(m_overrun));
            check("mem_rd",   RW'(bus.mem_rd), RW'(exp_rd));
            check("mem_addr", RW'(bus.mem_addr), RW'(exp_addr));
            if (bus.rowReady) ready_cnt++;
            if (bus.mem_rd && bus.mem_addr == 8'd199) addr199_cnt++;
        end
    end

    task automatic request(input int r);
        bus.rowNum = 8'(r);
        bus.LD_Row = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (bus.rowReady) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            tests++;
            errors++;
            $display("FAIL wait_ready: no rowReady within %0d cycles", budget);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_rem != 0 || bus.rowReady) && n < 40) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
    endtask

    logic [RW-1:0] exp_v;
    int lat, cnt0, a0;

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 16'h0100 + 16'(a);
        bus.LD_Row = 1'b0; bus.rowNum = 8'd0;
        bus.piece_valid = 1'b0; bus.piece_x = '0; bus.piece_y = '0; bus.piece_color = 16'h0000;
        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge Clk);
        check("reset_row", RW'(bus.Row), '0);
        check("reset_busy", RW'(bus.busy), '0);
        reset = 1'b0;
        @(negedge Clk);

        // Basic fetch of row 3
        request(3);
        bus.LD_Row = 1'b0;
        wait_ready(30, lat);
        check("basic_latency", RW'(lat), RW'(12));
        for (int k = 0; k < BOARD_W; k++) exp_v[k*DATA_W +: DATA_W] = 16'h011E + 16'(k);
        check("basic_row", RW'(bus.Row), exp_v);
        @(negedge Clk);
        check("basic_busy_after", RW'(bus.busy), '0);
        check("basic_ready_pulse", RW'(bus.rowReady), '0);

        // Overlay on row 5
        bus.piece_valid = 1'b1; bus.piece_color = 16'hF0F0;
        bus.piece_x = {4'd6, 4'd5, 4'd5, 4'd4};
        bus.piece_y = {5'd5, 5'd6, 5'd5, 5'd5};
        request(5);
        bus.LD_Row = 1'b0;
        wait_ready(30, lat);
        check("ovl_c3", RW'(bus.Row[3]), RW'(16'h0135));
        check("ovl_c4", RW'(bus.Row[4]), RW'(16'hF0F0));
        check("ovl_c5", RW'(bus.Row[5]), RW'(16'hF0F0));
        check("ovl_c6", RW'(bus.Row[6]), RW'(16'hF0F0));
        check("ovl_c7", RW'(bus.Row[7]), RW'(16'h0139));
        wait_idle();
        bus.piece_valid = 1'b0;
        request(5);
        bus.LD_Row = 1'b0;
        wait_ready(30, lat);
        check("noovl_c5", RW'(bus.Row[5]), RW'(16'h0137));
        wait_idle();

        // Out-of-range row and last legal row
        request(20);
        bus.LD_Row = 1'b0;
        wait_ready(5, lat);
        check("oor_latency", RW'(lat), RW'(1));
        check("oor_row", RW'(bus.Row), '0);
        wait_idle();
        a0 = addr199_cnt;
        request(19);
        bus.LD_Row = 1'b0;
        wait_ready(30, lat);
        @(negedge Clk);
        check("addr199_seen", RW'(addr199_cnt - a0), RW'(1));
        check("row19_c9", RW'(bus.Row[9]), RW'(16'h01C7));
        wait_idle();

        // Held request
        cnt0 = ready_cnt;
        bus.rowNum = 8'd7; bus.LD_Row = 1'b1;
        repeat (40) @(posedge Clk);
        #1 bus.LD_Row = 1'b0;
        repeat (3) @(negedge Clk);
        check("held_one_pulse", RW'(ready_cnt - cnt0), RW'(1));
        check("held_no_overrun", RW'(bus.overrun), '0);

        // Overrun: second edge 4 cycles into the fetch
        cnt0 = ready_cnt;
        request(2);
        bus.LD_Row = 1'b0;
        repeat (3) @(posedge Clk);
        #1 bus.LD_Row = 1'b1;
        @(posedge Clk);
        #1 bus.LD_Row = 1'b0;
        wait_ready(30, lat);
        check("overrun_set", RW'(bus.overrun), RW'(1));
        check("overrun_row_c0", RW'(bus.Row[0]), RW'(16'h0114));
        repeat (20) @(negedge Clk);
        check("overrun_not_serviced", RW'(ready_cnt - cnt0), RW'(1));
        check("overrun_sticky", RW'(bus.overrun), RW'(1));

        // Reset in the 5th FETCH cycle
        request(8);
        bus.LD_Row = 1'b0;
        repeat (4) @(posedge Clk);
        #2 reset = 1'b1;
        #1;
        check("rst_row", RW'(bus.Row), '0);
        check("rst_busy", RW'(bus.busy), '0);
        check("rst_mem_rd", RW'(bus.mem_rd), '0);
        check("rst_mem_addr", RW'(bus.mem_addr), '0);
        check("rst_overrun", RW'(bus.overrun), '0);
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        request(0);
        bus.LD_Row = 1'b0;
        wait_ready(30, lat);
        for (int k = 0; k < BOARD_W; k++) exp_v[k*DATA_W +: DATA_W] = 16'h0100 + 16'(k);
        check("post_rst_row0", RW'(bus.Row), exp_v);
        wait_idle();

        // Randomized requests, piece placements and stray edges
        for (int it = 0; it < 40; it++) begin
            int r, hold;
            r = int'($urandom_range(0, 22));
            bus.piece_valid = 1'($urandom_range(0, 1));
            bus.piece_color = 16'($urandom);
            for (int i = 0; i < 4; i++) begin
                bus.piece_x[i] = 4'($urandom_range(0, 11));
                bus.piece_y[i] = ($urandom_range(0, 1) == 1) ? 5'(r) : 5'($urandom_range(0, 31));
            end
            hold = int'($urandom_range(1, 4));
            request(r);
            repeat (hold - 1) @(posedge Clk);
            #1 bus.LD_Row = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) @(posedge Clk);
                #1 bus.LD_Row = 1'b1;
                @(posedge Clk);
                #1 bus.LD_Row = 1'b0;
            end
            wait_idle();
        end

        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
